// File: rtl/spi_arb_pkg.sv
// Shared state encoding and default timing for the two-requester SPI arbiter.
// Counter width bounds every timing parameter of the arbiter.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_WAITRUN,
        ST_BUSY,
        ST_LOCKED,
        ST_HOLD,
        ST_GAP
    } arb_state_e;

    localparam int CS_SETUP_DEF    = 2;
    localparam int CS_HOLD_DEF     = 2;
    localparam int CS_GAP_DEF      = 1;
    localparam int RUN_TIMEOUT_DEF = 4;
    localparam int CNT_W           = 8;

    // Where a finished (or timed-out) transfer goes when zero-length phases are skipped.
    function automatic arb_state_e release_state(input int hold, input int gap);
        if (hold > 0)
            return ST_HOLD;
        else if (gap > 0)
            return ST_GAP;
        else
            return ST_IDLE;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted most recently wins.
// The pointer only moves when the parent commits a grant via update_i.
module rr_arb2 (
    input  logic       clk,
    input  logic       resetq,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       gnt_o,
    output logic       valid_o
);

    logic last_q;

    always_comb begin
        valid_o = |req_i;
        gnt_o   = (&req_i) ? ~last_q : req_i[1];
    end

    // Reset pretends requester 1 went last so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            last_q <= 1'b1;
        else if (update_i && valid_o)
            last_q <= gnt_o;
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between two requesters, owning chip-select timing,
// locked bursts (last=0) and a run-start timeout.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int CS_SETUP    = CS_SETUP_DEF,
    parameter int CS_HOLD     = CS_HOLD_DEF,
    parameter int CS_GAP      = CS_GAP_DEF,
    parameter int RUN_TIMEOUT = RUN_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [1:0]  req,
    input  logic [1:0]  both,
    input  logic [1:0]  last,
    input  logic [15:0] tx0,
    input  logic [15:0] tx1,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [15:0] rx,
    output logic [1:0]  ssel_n,
    output logic        spi_we,
    output logic        spi_both,
    output logic [15:0] spi_tx,
    input  logic [15:0] spi_rx,
    input  logic        spi_running
);

    localparam arb_state_e REL_STATE = release_state(CS_HOLD, CS_GAP);

    arb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             gnt_q;
    logic             last_q;
    logic [1:0]       ssel_n_q;
    logic             spi_we_q;
    logic             spi_both_q;
    logic [15:0]      spi_tx_q;
    logic [1:0]       done_q;
    logic [1:0]       err_q;
    logic [15:0]      rx_q;

    logic             arb_gnt;
    logic             arb_valid;
    logic             arb_update;
    logic             sample_ok;
    logic             start_idx;
    logic [15:0]      start_tx;
    logic             start_both;
    logic             start_last;
    logic [1:0]       gnt_oh;

    rr_arb2 u_rr (
        .clk      (clk),
        .resetq   (resetq),
        .req_i    (req),
        .update_i (arb_update),
        .gnt_o    (arb_gnt),
        .valid_o  (arb_valid)
    );

    // A request still high during the done/err pulse belongs to the finished transfer.
    always_comb begin
        sample_ok  = ~(|done_q) & ~(|err_q);
        arb_update = (state_q == ST_IDLE) & sample_ok;
        start_idx  = (state_q == ST_IDLE) ? arb_gnt : gnt_q;
        start_tx   = start_idx ? tx1 : tx0;
        start_both = both[start_idx];
        start_last = last[start_idx];
        gnt_oh     = gnt_q ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gnt_q      <= 1'b0;
            last_q     <= 1'b0;
            ssel_n_q   <= 2'b11;
            spi_we_q   <= 1'b0;
            spi_both_q <= 1'b0;
            spi_tx_q   <= '0;
            done_q     <= '0;
            err_q      <= '0;
            rx_q       <= '0;
        end else begin
            spi_we_q <= 1'b0;
            done_q   <= '0;
            err_q    <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (arb_valid && sample_ok) begin
                        gnt_q    <= arb_gnt;
                        ssel_n_q <= arb_gnt ? 2'b01 : 2'b10;
                        cnt_q    <= '0;
                        if (CS_SETUP == 0) begin
                            state_q    <= ST_START;
                            spi_we_q   <= 1'b1;
                            spi_tx_q   <= start_tx;
                            spi_both_q <= start_both;
                            last_q     <= start_last;
                        end else begin
                            state_q <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                        state_q    <= ST_START;
                        spi_we_q   <= 1'b1;
                        spi_tx_q   <= start_tx;
                        spi_both_q <= start_both;
                        last_q     <= start_last;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_START: begin
                    state_q <= ST_WAITRUN;
                    cnt_q   <= CNT_W'(1);
                end
                // The START cycle counts as the first of the RUN_TIMEOUT cycles.
                ST_WAITRUN: begin
                    if (spi_running) begin
                        state_q <= ST_BUSY;
                    end else if (cnt_q >= CNT_W'(RUN_TIMEOUT - 1)) begin
                        err_q   <= gnt_oh;
                        cnt_q   <= '0;
                        state_q <= REL_STATE;
                        if (CS_HOLD == 0)
                            ssel_n_q <= 2'b11;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_BUSY: begin
                    if (!spi_running) begin
                        rx_q   <= spi_rx;
                        done_q <= gnt_oh;
                        cnt_q  <= '0;
                        if (last_q) begin
                            state_q <= REL_STATE;
                            if (CS_HOLD == 0)
                                ssel_n_q <= 2'b11;
                        end else begin
                            state_q <= ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (sample_ok && req[gnt_q]) begin
                        state_q    <= ST_START;
                        spi_we_q   <= 1'b1;
                        spi_tx_q   <= start_tx;
                        spi_both_q <= start_both;
                        last_q     <= start_last;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                        ssel_n_q <= 2'b11;
                        cnt_q    <= '0;
                        state_q  <= (CS_GAP > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CNT_W'(CS_GAP - 1))
                        state_q <= ST_IDLE;
                    else
                        cnt_q <= cnt_q + CNT_W'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign done     = done_q;
    assign err      = err_q;
    assign rx       = rx_q;
    assign ssel_n   = ssel_n_q;
    assign spi_we   = spi_we_q;
    assign spi_both = spi_both_q;
    assign spi_tx   = spi_tx_q;

endmodule
